// File: rtl/mem_arb_if.sv
// Bundle of the IFU, LSU and shared-memory signals around the memory arbiter.
// The arbiter uses the slave modport; the surrounding environment uses master.
interface mem_arb_if #(parameter int XLEN = 64);
    logic            ifu_req_valid;
    logic            ifu_req_ready;
    logic [XLEN-1:0] ifu_addr;
    logic            ifu_resp_valid;
    logic [XLEN-1:0] ifu_rdata;

    logic            lsu_req_valid;
    logic            lsu_req_ready;
    logic [XLEN-1:0] lsu_addr;
    logic            lsu_wen;
    logic [2:0]      lsu_type;
    logic [XLEN-1:0] lsu_wdata;
    logic            lsu_resp_valid;
    logic [XLEN-1:0] lsu_rdata;
    logic            lsu_err;

    logic            mem_req_valid;
    logic            mem_req_ready;
    logic [XLEN-1:0] mem_addr;
    logic            mem_wen;
    logic [XLEN-1:0] mem_wdata;
    logic [7:0]      mem_wmask;
    logic            mem_resp_valid;
    logic [XLEN-1:0] mem_rdata;

    modport slave (
        input  ifu_req_valid, ifu_addr,
        input  lsu_req_valid, lsu_addr, lsu_wen, lsu_type, lsu_wdata,
        input  mem_req_ready, mem_resp_valid, mem_rdata,
        output ifu_req_ready, ifu_resp_valid, ifu_rdata,
        output lsu_req_ready, lsu_resp_valid, lsu_rdata, lsu_err,
        output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask
    );

    modport master (
        output ifu_req_valid, ifu_addr,
        output lsu_req_valid, lsu_addr, lsu_wen, lsu_type, lsu_wdata,
        output mem_req_ready, mem_resp_valid, mem_rdata,
        input  ifu_req_ready, ifu_resp_valid, ifu_rdata,
        input  lsu_req_ready, lsu_resp_valid, lsu_rdata, lsu_err,
        input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask
    );
endinterface

// File: rtl/mem_arb.sv
// Round-robin arbiter sharing one memory port between the IFU and LSU, with
// LSU byte-lane alignment, load extension and misalignment detection.
//
// state | meaning
// IDLE  | grant one requester, latch its fields
// REQ   | present request on memory port until mem_req_ready
// WAIT  | wait for mem_resp_valid, capture read word
// RESP  | one-cycle response strobe to the owner
module mem_arb #(
    parameter int XLEN    = 64,
    parameter bit RR_INIT = 1'b0
) (
    input  logic     clk,
    input  logic     rst_n,
    mem_arb_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] RESP = 2'd3;

    logic [1:0]      state;
    logic            rr;
    logic            owner;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] rdata_q;
    logic [XLEN-1:0] wdata_q;
    logic [7:0]      wmask_q;
    logic [2:0]      type_q;
    logic            wen_q;
    logic            err_q;

    logic            grant_ifu;
    logic            grant_lsu;
    logic [2:0]      lsu_off;
    logic [2:0]      align_mask;
    logic [7:0]      size_mask;
    logic            lsu_misaligned;
    logic [7:0]      lsu_wmask;
    logic [XLEN-1:0] lsu_wdata_sh;
    logic [XLEN-1:0] ld_sh;
    logic [XLEN-1:0] ld_ext;
    logic            sx;

    // Grants are gated by rst_n so ready stays low while reset is held.
    always_comb begin
        grant_ifu = 1'b0;
        grant_lsu = 1'b0;
        if (state == IDLE && rst_n) begin
            if (bus.ifu_req_valid && bus.lsu_req_valid) begin
                grant_lsu = rr;
                grant_ifu = !rr;
            end else begin
                grant_ifu = bus.ifu_req_valid;
                grant_lsu = bus.lsu_req_valid;
            end
        end
    end

    assign bus.ifu_req_ready = grant_ifu;
    assign bus.lsu_req_ready = grant_lsu;

    assign lsu_off = bus.lsu_addr[2:0];

    always_comb begin
        align_mask = 3'b000;
        size_mask  = 8'h01;
        case (bus.lsu_type[1:0])
            2'd0:    begin align_mask = 3'b000; size_mask = 8'h01; end
            2'd1:    begin align_mask = 3'b001; size_mask = 8'h03; end
            2'd2:    begin align_mask = 3'b011; size_mask = 8'h0F; end
            default: begin align_mask = 3'b111; size_mask = 8'hFF; end
        endcase
    end

    assign lsu_misaligned = |(lsu_off & align_mask);
    assign lsu_wmask      = size_mask << lsu_off;
    assign lsu_wdata_sh   = bus.lsu_wdata << {lsu_off, 3'b000};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            rr      <= RR_INIT;
            owner   <= 1'b0;
            addr_q  <= '0;
            rdata_q <= '0;
            wdata_q <= '0;
            wmask_q <= 8'h00;
            type_q  <= 3'd0;
            wen_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_ifu) begin
                        owner   <= 1'b0;
                        addr_q  <= bus.ifu_addr;
                        wdata_q <= '0;
                        wmask_q <= 8'hFF;
                        type_q  <= 3'd3;
                        wen_q   <= 1'b0;
                        err_q   <= 1'b0;
                        rr      <= 1'b1;
                        state   <= REQ;
                    end else if (grant_lsu) begin
                        owner   <= 1'b1;
                        addr_q  <= bus.lsu_addr;
                        wdata_q <= lsu_wdata_sh;
                        wmask_q <= lsu_wmask;
                        type_q  <= bus.lsu_type;
                        wen_q   <= bus.lsu_wen;
                        err_q   <= lsu_misaligned;
                        rr      <= 1'b0;
                        // misaligned accesses never touch memory
                        state   <= lsu_misaligned ? RESP : REQ;
                    end
                end
                REQ: begin
                    if (bus.mem_req_ready) state <= WAIT;
                end
                WAIT: begin
                    if (bus.mem_resp_valid) begin
                        rdata_q <= bus.mem_rdata;
                        state   <= RESP;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.mem_req_valid = (state == REQ);
    assign bus.mem_addr      = {addr_q[XLEN-1:3], 3'b000};
    assign bus.mem_wen       = wen_q;
    assign bus.mem_wdata     = wdata_q;
    assign bus.mem_wmask     = wmask_q;

    assign ld_sh = rdata_q >> {addr_q[2:0], 3'b000};

    always_comb begin
        ld_ext = ld_sh;
        sx     = 1'b0;
        case (type_q[1:0])
            2'd0: begin
                sx     = !type_q[2] && ld_sh[7];
                ld_ext = {{(XLEN-8){sx}}, ld_sh[7:0]};
            end
            2'd1: begin
                sx     = !type_q[2] && ld_sh[15];
                ld_ext = {{(XLEN-16){sx}}, ld_sh[15:0]};
            end
            2'd2: begin
                sx     = !type_q[2] && ld_sh[31];
                ld_ext = {{(XLEN-32){sx}}, ld_sh[31:0]};
            end
            default: ld_ext = ld_sh;
        endcase
    end

    assign bus.ifu_resp_valid = (state == RESP) && !owner;
    assign bus.ifu_rdata      = bus.ifu_resp_valid ? rdata_q : '0;
    assign bus.lsu_resp_valid = (state == RESP) && owner;
    assign bus.lsu_err        = bus.lsu_resp_valid && err_q;
    assign bus.lsu_rdata      = (bus.lsu_resp_valid && !err_q && !wen_q) ? ld_ext : '0;
endmodule

// File: tb/tb_mem_arb.sv
// Self-checking bench for mem_arb: vector table plus scoreboard of expected
// responses, and hand-written sequences for arbitration and mid-flight reset.
module tb_mem_arb;
    localparam int XLEN = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_arb_if #(.XLEN(XLEN)) bus();

    mem_arb #(.XLEN(XLEN), .RR_INIT(1'b0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        bit          is_lsu;
        logic [63:0] addr;
        bit          wen;
        logic [2:0]  typ;
        logic [63:0] wdata;
        logic [63:0] mrdata;
        bit          err;
        logic [63:0] rdata;
        logic [7:0]  wmask;
        logic [63:0] mwdata;
        logic [63:0] maddr;
    } vec_t;

    typedef struct {
        bit          is_lsu;
        bit          err;
        bit          chk_rdata;
        logic [63:0] rdata;
        int          cyc;
    } sb_t;

    int   n_cmp  = 0;
    int   n_fail = 0;
    int   n_resp = 0;
    int   cyc    = 0;
    sb_t  sb[$];
    sb_t  e_mon;
    vec_t vecs[13];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tmo(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: got timeout, want event (t=%0t)", name, $time);
    endtask

    // Response monitor: pops the scoreboard whenever a response strobe appears.
    always @(negedge clk) begin
        if (bus.ifu_resp_valid || bus.lsu_resp_valid) begin
            n_resp++;
            chk("single_resp", {bus.ifu_resp_valid, bus.lsu_resp_valid} == 2'b11, 0);
            if (sb.size() == 0) begin
                tmo("unexpected_resp");
            end else begin
                e_mon = sb.pop_front();
                chk("resp_owner", bus.lsu_resp_valid, e_mon.is_lsu);
                chk("resp_cycle", 64'(cyc), 64'(e_mon.cyc));
                if (e_mon.is_lsu) begin
                    chk("lsu_err", bus.lsu_err, e_mon.err);
                    if (e_mon.chk_rdata) chk("lsu_rdata", bus.lsu_rdata, e_mon.rdata);
                end else begin
                    chk("ifu_rdata", bus.ifu_rdata, e_mon.rdata);
                end
            end
        end
    end

    task automatic wait_grant(output bit ok);
        int t = 0;
        #1;
        while (!(bus.ifu_req_ready || bus.lsu_req_ready) && t < 20) begin
            @(negedge clk); #1; t++;
        end
        ok = bus.ifu_req_ready || bus.lsu_req_ready;
        if (!ok) tmo("grant_timeout");
    endtask

    task automatic serve_mem(input logic [63:0] rd, input bit chk_f, input logic [63:0] maddr,
                             input logic [7:0] wmask, input logic [63:0] mwdata, input bit wen);
        int t = 0;
        @(negedge clk); #1;
        while (!bus.mem_req_valid && t < 20) begin
            @(negedge clk); #1; t++;
        end
        if (!bus.mem_req_valid) begin
            tmo("mem_req_timeout");
            return;
        end
        chk("ready_low_in_req", {bus.ifu_req_ready, bus.lsu_req_ready}, 0);
        if (chk_f) begin
            chk("mem_addr", bus.mem_addr, maddr);
            chk("mem_wmask", bus.mem_wmask, wmask);
            chk("mem_wen", bus.mem_wen, wen);
            if (wen) chk("mem_wdata", bus.mem_wdata, mwdata);
        end
        bus.mem_req_ready = 1'b1;
        @(negedge clk);
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = rd;
        @(negedge clk);
        bus.mem_resp_valid = 1'b0;
        bus.mem_rdata      = '0;
    endtask

    task automatic wait_resp(input int start);
        int t = 0;
        #1;
        while (n_resp == start && t < 10) begin
            @(negedge clk); #1; t++;
        end
        if (n_resp == start) tmo("resp_timeout");
    endtask

    task automatic run_vec(input vec_t v);
        bit ok;
        int start;
        sb_t e;
        @(negedge clk);
        if (v.is_lsu) begin
            bus.lsu_req_valid = 1'b1;
            bus.lsu_addr      = v.addr;
            bus.lsu_wen       = v.wen;
            bus.lsu_type      = v.typ;
            bus.lsu_wdata     = v.wdata;
        end else begin
            bus.ifu_req_valid = 1'b1;
            bus.ifu_addr      = v.addr;
        end
        wait_grant(ok);
        if (!ok) begin
            bus.ifu_req_valid = 1'b0;
            bus.lsu_req_valid = 1'b0;
            return;
        end
        e.is_lsu    = v.is_lsu;
        e.err       = v.err;
        e.chk_rdata = !(v.wen && !v.err);
        e.rdata     = v.rdata;
        e.cyc       = v.err ? cyc + 1 : cyc + 3;
        sb.push_back(e);
        start = n_resp;
        @(posedge clk); #1;
        bus.ifu_req_valid = 1'b0;
        bus.lsu_req_valid = 1'b0;
        if (v.err) begin
            @(negedge clk); #1;
            chk("no_mem_req_on_err", bus.mem_req_valid, 0);
        end else begin
            serve_mem(v.mrdata, 1'b1, v.maddr, v.wmask, v.mwdata, v.wen);
        end
        wait_resp(start);
    endtask

    function automatic logic any_output();
        return |{bus.ifu_req_ready, bus.ifu_resp_valid, bus.ifu_rdata,
                 bus.lsu_req_ready, bus.lsu_resp_valid, bus.lsu_rdata, bus.lsu_err,
                 bus.mem_req_valid, bus.mem_addr, bus.mem_wen, bus.mem_wdata, bus.mem_wmask};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit   ok;
        int   start;
        sb_t  e;

        //          lsu  addr            wen typ   wdata                  mrdata                 err rdata                  wmask  mwdata                 maddr
        vecs[0]  = '{0, 64'h80000000, 0, 3'd0, 64'h0,                 64'h1122334455667788, 0, 64'h1122334455667788, 8'hFF, 64'h0,                 64'h80000000};
        vecs[1]  = '{1, 64'h80000003, 1, 3'd0, 64'hAB,                64'h0,                0, 64'h0,                8'h08, 64'hAB000000,          64'h80000000};
        vecs[2]  = '{1, 64'h80000002, 0, 3'd1, 64'h0,                 64'h0000000080010000, 0, 64'hFFFFFFFFFFFF8001, 8'h0C, 64'h0,                 64'h80000000};
        vecs[3]  = '{1, 64'h80000002, 0, 3'd5, 64'h0,                 64'h0000000080010000, 0, 64'h0000000000008001, 8'h0C, 64'h0,                 64'h80000000};
        vecs[4]  = '{1, 64'h80000006, 0, 3'd2, 64'h0,                 64'h0,                1, 64'h0,                8'h00, 64'h0,                 64'h0};
        vecs[5]  = '{1, 64'h00001007, 0, 3'd0, 64'h0,                 64'h8500000000000000, 0, 64'hFFFFFFFFFFFFFF85, 8'h80, 64'h0,                 64'h00001000};
        vecs[6]  = '{1, 64'h00001004, 0, 3'd6, 64'h0,                 64'hDEADBEEF00000000, 0, 64'h00000000DEADBEEF, 8'hF0, 64'h0,                 64'h00001000};
        vecs[7]  = '{1, 64'h00001004, 0, 3'd2, 64'h0,                 64'hDEADBEEF00000000, 0, 64'hFFFFFFFFDEADBEEF, 8'hF0, 64'h0,                 64'h00001000};
        vecs[8]  = '{1, 64'h00002000, 0, 3'd7, 64'h0,                 64'h8877665544332211, 0, 64'h8877665544332211, 8'hFF, 64'h0,                 64'h00002000};
        vecs[9]  = '{1, 64'h00002008, 1, 3'd3, 64'h0123456789ABCDEF, 64'h0,                0, 64'h0,                8'hFF, 64'h0123456789ABCDEF, 64'h00002008};
        vecs[10] = '{1, 64'h00002001, 1, 3'd1, 64'h1234,              64'h0,                1, 64'h0,                8'h00, 64'h0,                 64'h0};
        vecs[11] = '{1, 64'h00003004, 1, 3'd2, 64'h12345678,          64'h0,                0, 64'h0,                8'hF0, 64'h1234567800000000, 64'h00003000};
        vecs[12] = '{0, 64'h80000004, 0, 3'd0, 64'h0,                 64'h000000000000CAFE, 0, 64'h000000000000CAFE, 8'hFF, 64'h0,                 64'h80000000};

        bus.ifu_req_valid  = 1'b1;
        bus.ifu_addr       = 64'h80000000;
        bus.lsu_req_valid  = 1'b1;
        bus.lsu_addr       = '0;
        bus.lsu_wen        = 1'b0;
        bus.lsu_type       = 3'd0;
        bus.lsu_wdata      = '0;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_rdata      = '0;

        // Reset state: outputs low even with both requests pending.
        #12;
        chk("reset_outputs_zero", any_output(), 0);
        @(negedge clk);
        bus.ifu_req_valid = 1'b0;
        bus.lsu_req_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        chk("idle_no_grant", {bus.ifu_req_ready, bus.lsu_req_ready}, 0);

        for (int i = 0; i < 13; i++) run_vec(vecs[i]);

        // Both requesters valid continuously: grants must alternate.
        @(negedge clk);
        start = n_resp;
        @(negedge clk);
        chk("no_stray_resp", n_resp - start, 0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        bus.ifu_req_valid = 1'b1;
        bus.ifu_addr      = 64'h100;
        bus.lsu_req_valid = 1'b1;
        bus.lsu_addr      = 64'h200;
        bus.lsu_wen       = 1'b0;
        bus.lsu_type      = 3'd3;
        for (int i = 0; i < 4; i++) begin
            wait_grant(ok);
            if (!ok) break;
            chk("rr_one_ready", bus.ifu_req_ready && bus.lsu_req_ready, 0);
            chk("rr_owner", bus.lsu_req_ready, (i % 2));
            e.is_lsu    = bus.lsu_req_ready;
            e.err       = 1'b0;
            e.chk_rdata = 1'b1;
            e.rdata     = 64'hA000 + 64'(i);
            e.cyc       = cyc + 3;
            sb.push_back(e);
            start = n_resp;
            @(posedge clk); #1;
            serve_mem(64'hA000 + 64'(i), 1'b0, '0, '0, '0, 1'b0);
            wait_resp(start);
        end
        bus.ifu_req_valid = 1'b0;
        bus.lsu_req_valid = 1'b0;

        // Reset while waiting on memory: transaction vanishes, next one is served.
        @(negedge clk);
        bus.ifu_req_valid = 1'b1;
        bus.ifu_addr      = 64'h4008;
        wait_grant(ok);
        @(posedge clk); #1;
        bus.ifu_req_valid = 1'b0;
        @(negedge clk); #1;
        chk("abort_req_valid", bus.mem_req_valid, 1);
        bus.mem_req_ready = 1'b1;
        @(negedge clk);
        bus.mem_req_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_reset_outputs_zero", any_output(), 0);
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = 64'hBAD0BAD0BAD0BAD0;
        bus.ifu_req_valid  = 1'b1;
        bus.ifu_addr       = 64'h5000;
        #1;
        chk("mid_reset_ready_low", bus.ifu_req_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("first_idle_grant", bus.ifu_req_ready, 1);
        e.is_lsu    = 1'b0;
        e.err       = 1'b0;
        e.chk_rdata = 1'b1;
        e.rdata     = 64'h0F0F0F0F12345678;
        e.cyc       = cyc + 3;
        sb.push_back(e);
        start = n_resp;
        @(posedge clk); #1;
        bus.ifu_req_valid  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_rdata      = '0;
        serve_mem(64'h0F0F0F0F12345678, 1'b1, 64'h5000, 8'hFF, '0, 1'b0);
        wait_resp(start);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 64'(sb.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
